// File: rtl/oled_i2c_arbiter.sv
// Round-robin byte arbiter that shares one SSD1306 I2C byte master between the
// init sequencer (port 0) and the framebuffer streamer (port 1).
`timescale 1ns/1ps
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for an eligible requester and for the master to be idle
// ISSUE     | m_start held high until the master reports busy
// WAIT_DONE | master working; waiting for m_done or timeout
// GAP       | enforced idle time before the next grant
module oled_i2c_arbiter #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 16,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_is_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    output logic       req0_done,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_is_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    output logic       req1_done,
    output logic       req1_err,
    output logic       m_start,
    output logic [7:0] m_data,
    output logic       m_is_cmd,
    input  logic       m_busy,
    input  logic       m_done,
    output logic       grant_id,
    output logic [7:0] err_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             last_grant_q, last_grant_d;
    logic             lock_active_q, lock_active_d;
    logic             grant_id_q, grant_id_d;
    logic             m_start_q, m_start_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_is_cmd_q, m_is_cmd_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic win_valid;
    logic win_port;

    // While a lock is held only its owner (the last winner) may be granted.
    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (lock_active_q) begin
            win_port  = last_grant_q;
            win_valid = last_grant_q ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            win_valid = 1'b1;
            win_port  = ~last_grant_q;
        end else if (req0_valid) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (req1_valid) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        grant_id_d    = grant_id_q;
        m_start_d     = m_start_q;
        m_data_d      = m_data_q;
        m_is_cmd_d    = m_is_cmd_q;
        ready_d       = 2'b00;
        done_d        = 2'b00;
        err_d         = 2'b00;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!m_busy && win_valid) begin
                    m_data_d          = win_port ? req1_data : req0_data;
                    m_is_cmd_d        = ~(win_port ? req1_is_data : req0_is_data);
                    grant_id_d        = win_port;
                    last_grant_d      = win_port;
                    ready_d[win_port] = 1'b1;
                    lock_active_d     = win_port ? req1_lock : req0_lock;
                    cnt_d             = '0;
                    m_start_d         = 1'b1;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                // A real completion beats a timeout landing on the same cycle.
                if (state_q == ST_WAIT_DONE && m_done) begin
                    done_d[grant_id_q] = 1'b1;
                    m_start_d          = 1'b0;
                    gap_d              = GAP_LAST;
                    state_d            = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    done_d[grant_id_q] = 1'b1;
                    err_d[grant_id_q]  = 1'b1;
                    m_start_d          = 1'b0;
                    lock_active_d      = 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    gap_d   = GAP_LAST;
                    state_d = ST_GAP;
                end else if (state_q == ST_ISSUE && m_busy) begin
                    m_start_d = 1'b0;
                    state_d   = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            gap_q         <= '0;
            last_grant_q  <= 1'b1;
            lock_active_q <= 1'b0;
            grant_id_q    <= 1'b0;
            m_start_q     <= 1'b0;
            m_data_q      <= 8'h00;
            m_is_cmd_q    <= 1'b0;
            ready_q       <= 2'b00;
            done_q        <= 2'b00;
            err_q         <= 2'b00;
            err_cnt_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            grant_id_q    <= grant_id_d;
            m_start_q     <= m_start_d;
            m_data_q      <= m_data_d;
            m_is_cmd_q    <= m_is_cmd_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign m_start    = m_start_q;
    assign m_data     = m_data_q;
    assign m_is_cmd   = m_is_cmd_q;
    assign grant_id   = grant_id_q;
    assign err_cnt    = err_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/oled_i2c_arbiter.md
Name: oled_i2c_arbiter

Overview:
- Shares the single-byte SSD1306 I2C master (start/busy/done byte interface) between two requesters: the OLED init sequencer (port 0) and the framebuffer/text streamer (port 1).
- Arbitrates round-robin per byte, with an optional lock that lets one requester send an uninterrupted multi-byte sequence.
- Drives the master's start, data and is_cmd inputs, and supervises each transfer with a timeout.
- Sits between the requesters and the I2C master inside the OLED top level.

Parameters:
- TIMEOUT_CYCLES, 50000000: max cycles from grant to master done (500 ms at 100 MHz); on expiry the transfer is aborted with an error.
- GAP_CYCLES, 16: idle cycles enforced after every completed or aborted transfer before the next grant.
- CNT_W, 26: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a byte pending
- req0_data  in  8  byte to send
- req0_is_data  in  1  1 = display RAM data (control byte 0x40), 0 = command (control byte 0x00)
- req0_lock  in  1  hold grant for requester 0 after this byte
- req0_ready  out  1  1-cycle pulse: byte accepted, data latched
- req0_done  out  1  1-cycle pulse: transfer finished
- req0_err  out  1  valid only with req0_done; 1 = timeout
- req1_valid, req1_data, req1_is_data, req1_lock, req1_ready, req1_done, req1_err: same as port 0, for requester 1
- m_start  out  1  start request to master
- m_data  out  8  byte to master
- m_is_cmd  out  1  1 = command; driven as the inverse of the latched is_data
- m_busy  in  1  master busy
- m_done  in  1  master 1-cycle done pulse
- grant_id  out  1  owner of the current or last transfer
- err_cnt  out  8  saturating timeout count, for debug LEDs
- state_dbg  out  3  FSM state encoding

Behaviour:
- Reset values (asynchronous, active-low): every output 0, FSM = IDLE, last_grant = 1 (so port 0 wins first), lock_active = 0, counters 0.
- FSM states, encoded IDLE=0, ISSUE=1, WAIT_DONE=2, GAP=3.
- IDLE:
  - No grant while m_busy = 1.
  - If lock_active, only the lock owner is eligible. If the owner's valid is low, wait; the other port stays blocked.
  - Otherwise, with both valid, grant the port that is not last_grant; with one valid, grant that port.
  - Grant cycle actions:
    - Latch data and is_data into m_data/m_is_cmd.
    - Set grant_id and last_grant to the winner.
    - Pulse the winner's reqN_ready.
    - Set lock_active = winner's lock.
    - Clear the timeout counter, go to ISSUE.
  - Requesters must hold valid/data stable until ready. They may change them the cycle after ready.
- ISSUE:
  - m_start = 1; the timeout counter increments each cycle.
  - m_busy = 1 → m_start = 0 next cycle, go to WAIT_DONE.
- WAIT_DONE:
  - m_start = 0; the timeout counter keeps incrementing.
  - m_done = 1 → pulse reqN_done with reqN_err = 0, go to GAP.
- Timeout (ISSUE or WAIT_DONE):
  - Counter reaches TIMEOUT_CYCLES-1 without completion → drop m_start, pulse reqN_done with reqN_err = 1.
  - Increment err_cnt, saturating at 255.
  - Clear lock_active, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Stray m_done outside WAIT_DONE (e.g. a late completion after a timeout) is ignored; no done pulse.
- If m_done and the timeout expire in the same cycle, done wins: err = 0, no err_cnt increment.
- Lock release: the owner deasserts lock on its next accepted byte; lock_active is re-evaluated at every grant.
- ready, done and err are single-cycle, never asserted on both ports at once.
- Reset mid-transfer returns to reset values at once. No done pulse is issued for the aborted byte.

Test Plan:
- Port 0 only: valid, data 0x8D, is_data 0; master model busy 3 cycles after start, done 100 cycles later → req0_ready 1 cycle, m_data = 0x8D, m_is_cmd = 1, m_start high until busy, req0_done with err = 0, 16 GAP cycles, then IDLE.
- Both ports valid continuously, 4 bytes each, lock = 0 → grants alternate 0,1,0,1,…, port 0 first after reset; byte order preserved within each port.
- Port 0 sends 0x8D, 0x14, 0xAF with lock = 1,1,0 while port 1 is valid throughout → all three port-0 bytes are granted consecutively, then port 1 is granted.
- TIMEOUT_CYCLES = 1000, master never asserts busy:
  - Required response: req1_err pulses exactly 1000 cycles after the grant, m_start drops, err_cnt = 1.
  - A later stray m_done produces no done pulse.
- m_busy held high at the end of GAP → no grant until m_busy falls. Also, m_done and timeout in the same cycle → err = 0, err_cnt unchanged.
- rst_n pulsed low during WAIT_DONE → all outputs 0 asynchronously, and no done pulse. After release, the next grant goes to port 0.
